lsu_mem_stage: RTL and testbench

Load/store unit for the memory stage, directly upstream of the data cache. Accepts one load or store per handshake from the execute stage, converts it into word-granular data-cache accesses (read-modify-write for byte/halfword stores, since the cache writes whole words only), and returns sign/zero-extended load data or store completion. One request is outstanding at a time.

---
 rtl/lsu_mem_stage.sv | 178 +++++++++++++++++
 tb/tb_lsu_mem_stage.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit: one outstanding request, word-granular cache access with RMW.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned requests return resp_err).
module lsu_mem_stage #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_data,
   output logic              resp_err,
   output logic [ADDR_W-1:0] mem_raddr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [DATA_W-1:0] mem_wdata
);

   typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

   state_e            state_q, state_d;
   logic              we_q;
   logic              uns_q;
   logic              err_q;
   logic [1:0]        size_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] word_q;

   logic              handshake;
   logic              misalign;
   logic              err_in;
   logic [ADDR_W-1:0] addr_in;
   logic [ADDR_W-1:0] addr_aligned;
   logic [7:0]        byte_sel;
   logic [15:0]       half_sel;
   logic [DATA_W-1:0] load_data;
   logic [DATA_W-1:0] merged;

   assign handshake = req_valid & req_ready;

   // Sizes 2 and 3 are both word accesses, so req_size[1] means "word".
   assign misalign = ((req_size == 2'd1) & req_addr[0]) |
                     (req_size[1] & (req_addr[1:0] != 2'b00));

`ifdef LSU_MISALIGN_TRAP_EN
   assign err_in  = misalign;
   assign addr_in = req_addr;
`else
   assign err_in = 1'b0;
   // Silently align the request instead of trapping.
   always_comb begin
      addr_in = req_addr;
      if (req_size == 2'd1) begin
         addr_in[0] = 1'b0;
      end else if (req_size[1]) begin
         addr_in[1:0] = 2'b00;
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (handshake) begin
               if (err_in) begin
                  state_d = StResp;
               end else if (!req_we) begin
                  state_d = StRd;
               end else if (req_size[1]) begin
                  state_d = StWr;
               end else begin
                  state_d = StRd;
               end
            end
         end
         StRd:    state_d = we_q ? StWr : StResp;
         StWr:    state_d = StResp;
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         err_q   <= 1'b0;
         size_q  <= 2'd0;
         addr_q  <= '0;
         wdata_q <= '0;
         word_q  <= '0;
      end else begin
         state_q <= state_d;
         if (handshake) begin
            we_q    <= req_we;
            uns_q   <= req_unsigned;
            err_q   <= err_in;
            size_q  <= req_size;
            addr_q  <= addr_in;
            wdata_q <= req_wdata;
         end
         if (state_q == StRd) begin
            word_q <= mem_rdata;
         end
      end
   end

   always_comb begin
      byte_sel = word_q[7:0];
      unique case (addr_q[1:0])
         2'd0: byte_sel = word_q[7:0];
         2'd1: byte_sel = word_q[15:8];
         2'd2: byte_sel = word_q[23:16];
         2'd3: byte_sel = word_q[31:24];
         default: byte_sel = word_q[7:0];
      endcase
   end

   assign half_sel = addr_q[1] ? word_q[31:16] : word_q[15:0];

   always_comb begin
      load_data = word_q;
      if (size_q == 2'd0) begin
         load_data = {{24{~uns_q & byte_sel[7]}}, byte_sel};
      end else if (size_q == 2'd1) begin
         load_data = {{16{~uns_q & half_sel[15]}}, half_sel};
      end
   end

   // Sub-word stores patch the captured word; word stores ignore it entirely.
   always_comb begin
      merged = wdata_q;
      if (size_q == 2'd0) begin
         merged = word_q;
         unique case (addr_q[1:0])
            2'd0: merged[7:0]   = wdata_q[7:0];
            2'd1: merged[15:8]  = wdata_q[7:0];
            2'd2: merged[23:16] = wdata_q[7:0];
            2'd3: merged[31:24] = wdata_q[7:0];
            default: merged[7:0] = wdata_q[7:0];
         endcase
      end else if (size_q == 2'd1) begin
         merged = word_q;
         if (addr_q[1]) begin
            merged[31:16] = wdata_q[15:0];
         end else begin
            merged[15:0] = wdata_q[15:0];
         end
      end
   end

   assign addr_aligned = {addr_q[ADDR_W-1:2], 2'b00};

   assign req_ready  = (state_q == StIdle);
   assign resp_valid = (state_q == StResp);
   assign resp_data  = (resp_valid && !we_q && !err_q) ? load_data : '0;
`ifdef LSU_MISALIGN_TRAP_EN
   assign resp_err   = resp_valid & err_q;
`else
   assign resp_err   = 1'b0;
`endif

   assign mem_raddr = addr_aligned;
   assign mem_waddr = addr_aligned;
   assign mem_wdata = merged;
   assign mem_we    = (state_q == StWr) & ~rst;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed self-checking bench for lsu_mem_stage with a small word-addressed cache model.
module tb_lsu_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        resp_err;
   logic [31:0] mem_raddr;
   logic [31:0] mem_rdata;
   logic        mem_we;
   logic [31:0] mem_waddr;
   logic [31:0] mem_wdata;

   logic [31:0] mem [0:255];
   int unsigned wr_count = 0;
   int          vectors  = 0;
   int          miscompares = 0;

   lsu_mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_data    (resp_data),
      .resp_err     (resp_err),
      .mem_raddr    (mem_raddr),
      .mem_rdata    (mem_rdata),
      .mem_we       (mem_we),
      .mem_waddr    (mem_waddr),
      .mem_wdata    (mem_wdata)
   );

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_raddr[9:2]];

   always @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr[9:2]] <= mem_wdata;
         wr_count <= wr_count + 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Presents one request for a single cycle; returns in the cycle after the handshake.
   task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
      req_we       = we;
      req_size     = size;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
      req_valid    = 1'b1;
      check("hs_ready", {31'b0, req_ready}, 32'd1);
      tick();
      req_valid = 1'b0;
   endtask

   task automatic do_load(input string tag, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] exp);
      issue(1'b0, size, uns, addr, 32'h0);
      check({tag, "_rd_valid"}, {31'b0, resp_valid}, 32'd0);
      tick();
      check({tag, "_valid"}, {31'b0, resp_valid}, 32'd1);
      check({tag, "_data"}, resp_data, exp);
      tick();
   endtask

   int unsigned wr_snap;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      rst          = 1'b1;
      req_valid    = 1'b0;
      req_we       = 1'b0;
      req_size     = 2'd0;
      req_unsigned = 1'b0;
      req_addr     = 32'h0;
      req_wdata    = 32'h0;
      tick();
      tick();
      check("rst_ready", {31'b0, req_ready}, 32'd1);
      check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      check("rst_resp_data", resp_data, 32'h0);
      check("rst_resp_err", {31'b0, resp_err}, 32'd0);
      check("rst_mem_we", {31'b0, mem_we}, 32'd0);
      rst = 1'b0;
      tick();

      // Word store: write at T+1, response at T+2.
      issue(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF);
      check("sw_we", {31'b0, mem_we}, 32'd1);
      check("sw_waddr", mem_waddr, 32'h100);
      check("sw_wdata", mem_wdata, 32'hDEADBEEF);
      check("sw_busy", {31'b0, req_ready}, 32'd0);
      tick();
      check("sw_resp", {31'b0, resp_valid}, 32'd1);
      check("sw_resp_data", resp_data, 32'h0);
      check("sw_we_off", {31'b0, mem_we}, 32'd0);
      tick();
      check("sw_pulse", {31'b0, resp_valid}, 32'd0);
      check("sw_idle", {31'b0, req_ready}, 32'd1);
      check("sw_mem", mem[8'h40], 32'hDEADBEEF);

      do_load("lw100", 2'd2, 1'b0, 32'h100, 32'hDEADBEEF);

      // Byte store RMW: read T+1, write T+2, response T+3.
      mem[8'h80] = 32'h11223344;
      issue(1'b1, 2'd0, 1'b0, 32'h201, 32'hFFFFFFAA);
      check("sb_rd_we", {31'b0, mem_we}, 32'd0);
      check("sb_raddr", mem_raddr, 32'h200);
      tick();
      check("sb_we", {31'b0, mem_we}, 32'd1);
      check("sb_waddr", mem_waddr, 32'h200);
      check("sb_wdata", mem_wdata, 32'h1122AA44);
      check("sb_no_resp", {31'b0, resp_valid}, 32'd0);
      tick();
      check("sb_resp", {31'b0, resp_valid}, 32'd1);
      tick();
      check("sb_mem", mem[8'h80], 32'h1122AA44);

      // Load extraction and extension.
      mem[8'hC0] = 32'h80FF7F01;
      do_load("lb303", 2'd0, 1'b0, 32'h303, 32'hFFFFFF80);
      do_load("lbu303", 2'd0, 1'b1, 32'h303, 32'h00000080);
      do_load("lh302", 2'd1, 1'b0, 32'h302, 32'hFFFF80FF);
      do_load("lhu300", 2'd1, 1'b1, 32'h300, 32'h00007F01);
      do_load("lb301", 2'd0, 1'b0, 32'h301, 32'h0000007F);

      // Misaligned halfword load.
      wr_snap = wr_count;
`ifdef LSU_MISALIGN_TRAP_EN
      issue(1'b0, 2'd1, 1'b0, 32'h301, 32'h0);
      check("mis_valid", {31'b0, resp_valid}, 32'd1);
      check("mis_err", {31'b0, resp_err}, 32'd1);
      check("mis_data", resp_data, 32'h0);
      check("mis_we", {31'b0, mem_we}, 32'd0);
      tick();
      check("mis_idle", {31'b0, req_ready}, 32'd1);
`else
      do_load("mis_lh301", 2'd1, 1'b0, 32'h301, 32'h00007F01);
`endif
      check("mis_no_write", wr_count, wr_snap);

      // Reset during the WR cycle of a halfword RMW store.
      wr_snap = wr_count;
      issue(1'b1, 2'd1, 1'b0, 32'h202, 32'h00005566);
      tick();
      rst = 1'b1;
      #1;
      check("rstwr_we", {31'b0, mem_we}, 32'd0);
      tick();
      rst = 1'b0;
      check("rstwr_ready", {31'b0, req_ready}, 32'd1);
      check("rstwr_resp", {31'b0, resp_valid}, 32'd0);
      check("rstwr_mem", mem[8'h80], 32'h1122AA44);
      check("rstwr_count", wr_count, wr_snap);
      tick();

      // Back-to-back loads with req_valid held high.
      req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h100;
      req_valid = 1'b1;
      check("b2b_ready0", {31'b0, req_ready}, 32'd1);
      tick();
      req_addr = 32'h300;
      check("b2b_busy1", {31'b0, req_ready}, 32'd0);
      tick();
      check("b2b_resp1", {31'b0, resp_valid}, 32'd1);
      check("b2b_data1", resp_data, 32'hDEADBEEF);
      check("b2b_busy2", {31'b0, req_ready}, 32'd0);
      tick();
      check("b2b_ready2", {31'b0, req_ready}, 32'd1);
      check("b2b_gap", {31'b0, resp_valid}, 32'd0);
      tick();
      req_valid = 1'b0;
      check("b2b_busy3", {31'b0, req_ready}, 32'd0);
      tick();
      check("b2b_resp2", {31'b0, resp_valid}, 32'd1);
      check("b2b_data2", resp_data, 32'h80FF7F01);
      tick();
      check("b2b_final", {31'b0, req_ready}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
